// File: rtl/ad_absorb.sv
// ad_absorb: ACORN-128 associated-data stage (bit-serial AD absorb, then 256-step AD padding).
// Optional feature: define AD_LEN_COUNTER_EN to drive ad_len_out with the absorbed AD bit count.

module state_update128 (
  input  logic [292:0] s_i,
  input  logic         m_i,
  input  logic         ca_i,
  input  logic         cb_i,
  output logic [292:0] s_o
);
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  logic [292:0] t;
  logic         ks;
  logic         f;

  // LFSR feedbacks are applied top-down, so each uses the pre-step value of the bit below it.
  always_comb begin
    t      = s_i;
    t[289] = t[289] ^ t[235] ^ t[230];
    t[230] = t[230] ^ t[196] ^ t[193];
    t[193] = t[193] ^ t[160] ^ t[154];
    t[154] = t[154] ^ t[111] ^ t[107];
    t[107] = t[107] ^ t[66]  ^ t[61];
    t[61]  = t[61]  ^ t[23]  ^ t[0];
    ks     = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
    f      = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca_i & t[196]) ^ (cb_i & ks) ^ m_i;
    s_o    = {f, t[292:1]};
  end
endmodule

module ad_absorb #(
  parameter int AD_MAX_BYTES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         ad_empty,
  input  logic [292:0] state_in,
  input  logic [7:0]   ad_data,
  input  logic         ad_valid,
  input  logic         ad_last,
  output logic         ad_ready,
  output logic         busy,
  output logic         done,
  output logic [292:0] state_out,
  output logic [63:0]  ad_len_out
);
  localparam int            CW       = $clog2(AD_MAX_BYTES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(AD_MAX_BYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(AD_MAX_BYTES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ABSORB = 2'd1;
  localparam logic [1:0] PAD    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]    fsm_q, fsm_d;
  logic [292:0]  st_q, st_d, st_upd;
  logic [7:0]    buf_q, buf_d;
  logic          full_q, full_d;
  logic          last_q, last_d;
  logic          hold_q, hold_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    pad_q, pad_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mbit, ca, cb;

  state_update128 u_upd (
    .s_i (st_q),
    .m_i (mbit),
    .ca_i(ca),
    .cb_i(cb),
    .s_o (st_upd)
  );

  // Step controls for the single update instance.
  always_comb begin
    mbit = 1'b0;
    ca   = 1'b0;
    cb   = 1'b0;
    case (fsm_q)
      ABSORB: begin
        mbit = buf_q[idx_q];
        ca   = 1'b1;
        cb   = 1'b1;
      end
      PAD: begin
        mbit = (pad_q == 8'd0);
        ca   = ~pad_q[7];
        cb   = 1'b1;
      end
      default: begin
        mbit = 1'b0;
      end
    endcase
  end

  // Next-state logic; hold_q gives zero-length AD the same one-cycle load slot as a real byte.
  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    buf_d  = buf_q;
    full_d = full_q;
    last_d = last_q;
    hold_d = hold_q;
    idx_d  = idx_q;
    pad_d  = pad_q;
    cnt_d  = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          st_d   = state_in;
          full_d = 1'b0;
          last_d = 1'b0;
          idx_d  = 3'd0;
          pad_d  = 8'd0;
          cnt_d  = '0;
          hold_d = ad_empty;
          fsm_d  = ad_empty ? PAD : ABSORB;
        end else begin
          fsm_d = IDLE;
        end
      end
      ABSORB: begin
        if (full_q) begin
          st_d  = st_upd;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            full_d = 1'b0;
            if (last_q) begin
              fsm_d = PAD;
              pad_d = 8'd0;
            end else begin
              fsm_d = ABSORB;
            end
          end else begin
            full_d = 1'b1;
          end
        end else begin
          st_d = st_q;
        end
        if (ad_valid && ready_q) begin
          buf_d  = ad_data;
          full_d = 1'b1;
          idx_d  = 3'd0;
          last_d = ad_last | (cnt_q >= CNT_LAST);
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          buf_d = buf_q;
        end
      end
      PAD: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          st_d  = st_upd;
          pad_d = pad_q + 8'd1;
          if (pad_q == 8'hFF) begin
            fsm_d = DONE;
          end else begin
            fsm_d = PAD;
          end
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
    busy_d  = (fsm_d == ABSORB) || (fsm_d == PAD);
    done_d  = (fsm_d == DONE);
    ready_d = (fsm_d == ABSORB) && (!full_d || ((idx_d == 3'd7) && !last_d));
  end

  // Working state and control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= IDLE;
      st_q    <= '0;
      buf_q   <= 8'd0;
      full_q  <= 1'b0;
      last_q  <= 1'b0;
      hold_q  <= 1'b0;
      idx_q   <= 3'd0;
      pad_q   <= 8'd0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      st_q    <= st_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      pad_q   <= pad_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ad_ready  = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = st_q;

`ifdef AD_LEN_COUNTER_EN
  logic [63:0] len_q, len_d;

  // One count per absorbed bit; saturates and holds after done.
  always_comb begin
    len_d = len_q;
    if ((fsm_q == IDLE) && start) begin
      len_d = 64'd0;
    end else if ((fsm_q == ABSORB) && full_q && (len_q != 64'hFFFF_FFFF_FFFF_FFFF)) begin
      len_d = len_q + 64'd1;
    end else begin
      len_d = len_q;
    end
  end

  // AD length register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= 64'd0;
    end else begin
      len_q <= len_d;
    end
  end

  assign ad_len_out = len_q;
`else
  assign ad_len_out = 64'd0;
`endif
endmodule
